// File: rtl/myo_spi_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : myo_spi_pkg
//  Description : Shared constants, FSM state encoding and the frame checksum
//                helper for the myocontrol SPI responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package myo_spi_pkg;

  localparam int WORD_W    = 16;
  // Upper bound on FRAME_WORDS that xor_fold can handle.
  localparam int MAX_WORDS = 64;

  typedef logic [1:0] state_t;
  localparam state_t IDLE       = 2'd0;
  localparam state_t SHIFT      = 2'd1;
  localparam state_t DONE       = 2'd2;
  localparam state_t WAIT_DESEL = 2'd3;

  // XOR of words 0..n_words-2 of a frame (the checksum over the payload).
  function automatic logic [WORD_W-1:0] xor_fold(
    input logic [WORD_W*MAX_WORDS-1:0] frame,
    input int unsigned                 n_words
  );
    logic [WORD_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
      if (i + 1 < n_words) acc ^= frame[i*WORD_W +: WORD_W];
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/myo_spi_responder_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : myo_spi_sync_edge
//  Description : Multi-flop synchronizer for one asynchronous input followed
//                by a rise/fall pulse detector in the clk domain.
//  Revision    : 1.0 - initial release
//  Ports       : clk_i    fabric clock
//                rst_i    asynchronous active-high reset
//                d_i      asynchronous input
//                level_o  synchronized level
//                rise_o   1-clk pulse on a synchronized 0->1 transition
//                fall_o   1-clk pulse on a synchronized 1->0 transition
// ============================================================================
module myo_spi_sync_edge #(
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Resetting to 0 makes a held-low ss_n look "still selected" after reset,
  // so the top waits for a real deselect before joining any frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/myo_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : myo_spi_responder
//  Description : SPI mode-1 slave emulating one myocontrol motor board.
//                Returns a status frame captured from tx_frame at frame start
//                and delivers the received command frame on rx_frame.
//  Revision    : 1.0 - initial release
//  Config      : MYO_SPI_RESPONDER_CHECKSUM_EN - last word of both frames is
//                the XOR of the others; tx checksum is regenerated and rx
//                frames with a bad checksum are rejected.
//  Ports       : clk, reset          fabric clock, async active-high reset
//                sck, ss_n, mosi     asynchronous SPI inputs
//                miso, miso_oe       SPI data out and pad output enable
//                tx_frame            status words, word0 = [15:0] sent first
//                rx_frame            last accepted command frame
//                rx_valid/frame_err  1-clk accept / reject pulses
//                busy                high while a frame is in progress
// ============================================================================
module myo_spi_responder
  import myo_spi_pkg::*;
#(
  parameter int FRAME_WORDS = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          ss_n,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic [WORD_W*FRAME_WORDS-1:0] tx_frame,
  output logic [WORD_W*FRAME_WORDS-1:0] rx_frame,
  output logic                          rx_valid,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int FW_BITS = WORD_W * FRAME_WORDS;
  localparam int WCNT_W  = $clog2(FRAME_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(FRAME_WORDS);

  logic w_sck_rise, w_sck_fall;
  logic w_ss_lvl, w_ss_rise;
  logic w_mosi_lvl;

  myo_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i(clk), .rst_i(reset), .d_i(sck),
    .level_o(), .rise_o(w_sck_rise), .fall_o(w_sck_fall)
  );

  myo_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk_i(clk), .rst_i(reset), .d_i(ss_n),
    .level_o(w_ss_lvl), .rise_o(w_ss_rise), .fall_o()
  );

  myo_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(clk), .rst_i(reset), .d_i(mosi),
    .level_o(w_mosi_lvl), .rise_o(), .fall_o()
  );

  state_t              state_q, state_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic [WCNT_W-1:0]   wordcnt_q, wordcnt_d;
  logic                overrun_q, overrun_d;
  logic [FW_BITS-1:0]  shadow_q, shadow_d;
  logic [WORD_W-1:0]   rxsh_q, rxsh_d;
  logic [FW_BITS-1:0]  staging_q, staging_d;
  logic [FW_BITS-1:0]  rx_frame_q, rx_frame_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                miso_q, miso_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;

  logic [FW_BITS-1:0]  w_tx_latch;
  logic                w_csum_ok;
  logic                w_good;
  logic [WORD_W-1:0]   w_shift_word;

`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  logic [WORD_W*MAX_WORDS-1:0] w_tx_ext;
  logic [WORD_W*MAX_WORDS-1:0] w_stg_ext;
  assign w_tx_ext   = (WORD_W*MAX_WORDS)'(tx_frame);
  assign w_stg_ext  = (WORD_W*MAX_WORDS)'(staging_q);
  assign w_tx_latch = {xor_fold(w_tx_ext, FRAME_WORDS), tx_frame[FW_BITS-WORD_W-1:0]};
  assign w_csum_ok  = (xor_fold(w_stg_ext, FRAME_WORDS) == staging_q[FW_BITS-1 -: WORD_W]);
`else
  assign w_tx_latch = tx_frame;
  assign w_csum_ok  = 1'b1;
`endif

  assign w_good       = (bitcnt_q == 4'd0) && (wordcnt_q == WCNT_FULL) && !overrun_q && w_csum_ok;
  assign w_shift_word = {rxsh_q[WORD_W-2:0], w_mosi_lvl};

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    wordcnt_d   = wordcnt_q;
    overrun_d   = overrun_q;
    shadow_d    = shadow_q;
    rxsh_d      = rxsh_q;
    staging_d   = staging_q;
    rx_frame_d  = rx_frame_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    oe_d        = oe_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        // IDLE is only entered with ss_n deselected, so a low level here is
        // a new fall; the level test also catches a fall during DONE.
        if (!w_ss_lvl) begin
          state_d   = SHIFT;
          shadow_d  = w_tx_latch;
          bitcnt_d  = 4'd0;
          wordcnt_d = '0;
          overrun_d = 1'b0;
          miso_d    = 1'b0;
          oe_d      = 1'b1;
          busy_d    = 1'b1;
        end
      end

      SHIFT: begin
        if (w_ss_rise) begin
          state_d = DONE;
        end else begin
          if (w_sck_rise) begin
            // {wordcnt, ~bitcnt} == wordcnt*16 + (15 - bitcnt) for 16-bit words
            miso_d = (wordcnt_q == WCNT_FULL) ? 1'b0 : shadow_q[{wordcnt_q, ~bitcnt_q}];
          end
          if (w_sck_fall) begin
            if (wordcnt_q == WCNT_FULL) begin
              overrun_d = 1'b1;
            end else begin
              rxsh_d   = w_shift_word;
              bitcnt_d = bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd15) begin
                staging_d[int'(wordcnt_q)*WORD_W +: WORD_W] = w_shift_word;
                wordcnt_d = wordcnt_q + 1'b1;
              end
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        miso_d  = 1'b0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        if (w_good) begin
          rx_frame_d = staging_q;
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: begin  // WAIT_DESEL: never join a frame already in progress
        if (w_ss_lvl) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_DESEL;
      bitcnt_q    <= 4'd0;
      wordcnt_q   <= '0;
      overrun_q   <= 1'b0;
      shadow_q    <= '0;
      rxsh_q      <= '0;
      staging_q   <= '0;
      rx_frame_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      wordcnt_q   <= wordcnt_d;
      overrun_q   <= overrun_d;
      shadow_q    <= shadow_d;
      rxsh_q      <= rxsh_d;
      staging_q   <= staging_d;
      rx_frame_q  <= rx_frame_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign busy      = busy_q;
  assign rx_frame  = rx_frame_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
